vx_tex_dcr_seq: RTL and testbench

VX_TEX_DCR_SEQ -- requirements
Module: VX_tex_dcr_seq

---
 rtl/vx_tex_dcr_seq_pkg.sv | 52 +++++
 rtl/vx_tex_dcr_seq_rr_arb.sv | 45 ++++
 rtl/vx_tex_dcr_seq.sv | 167 ++++++++++++++++
 tb/tb_vx_tex_dcr_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tex_dcr_seq_pkg.sv
// Texture DCR sequencer types: descriptor layout, DCR address map, FSM states.
// Shared by the sequencer, its arbiter and the bench.
package vx_tex_dcr_seq_pkg;

   localparam int TEX_LOD_MAX    = 3;
   localparam int TEX_MIP_CNT    = TEX_LOD_MAX + 1;
   // Longest sequence, STAGE write included.
   localparam int TEX_DCR_WRITES = 6 + TEX_MIP_CNT;

   localparam int DCR_ADDR_W = 12;
   localparam int DCR_DATA_W = 32;

   localparam int TEX_ADDR_W   = 32;
   localparam int TEX_FORMAT_W = 3;
   localparam int TEX_FILTER_W = 1;
   localparam int TEX_WRAP_W   = 2;
   localparam int TEX_LOGDIM_W = 4;
   localparam int TEX_MIPOFF_W = 20;

   localparam logic [DCR_ADDR_W-1:0] DCR_TEX_STAGE   = 12'h010;
   localparam logic [DCR_ADDR_W-1:0] DCR_TEX_ADDR    = 12'h011;
   localparam logic [DCR_ADDR_W-1:0] DCR_TEX_FORMAT  = 12'h012;
   localparam logic [DCR_ADDR_W-1:0] DCR_TEX_FILTER  = 12'h013;
   localparam logic [DCR_ADDR_W-1:0] DCR_TEX_WRAP    = 12'h014;
   localparam logic [DCR_ADDR_W-1:0] DCR_TEX_LOGDIM  = 12'h015;
   localparam logic [DCR_ADDR_W-1:0] DCR_TEX_MIPOFF0 = 12'h016;

   function automatic logic [DCR_ADDR_W-1:0] dcr_tex_mipoff(input logic [DCR_ADDR_W-1:0] j);
      return DCR_TEX_MIPOFF0 + j;
   endfunction

   typedef struct packed {
      logic [TEX_LOD_MAX:0][TEX_MIPOFF_W-1:0] mipoff;
      logic [1:0][TEX_LOGDIM_W-1:0]           logdims;
      logic [1:0][TEX_WRAP_W-1:0]             wraps;
      logic [TEX_FILTER_W-1:0]                filter;
      logic [TEX_FORMAT_W-1:0]                format;
      logic [TEX_ADDR_W-1:0]                  baseaddr;
   } tex_dcrs_t;

   typedef enum logic [2:0] {
      TEX_DCR_IDLE,
      TEX_DCR_STAGE,
      TEX_DCR_ADDR,
      TEX_DCR_FORMAT,
      TEX_DCR_FILTER,
      TEX_DCR_WRAP,
      TEX_DCR_LOGDIM,
      TEX_DCR_MIPOFF
   } tex_dcr_state_e;

endpackage

// File: rtl/vx_tex_dcr_seq_rr_arb.sv
// Round-robin arbiter: picks one requester, search starts one past the last winner.
// Latency: grant is combinational from req; pointer moves on the cycle advance is high.
// Backpressure: none; the caller decides when a grant is taken via advance.
module vx_tex_dcr_seq_rr_arb #(
   parameter  int NUM_REQS = 2,
   localparam int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQS-1:0] req,
   input  logic                advance,
   output logic [NUM_REQS-1:0] grant,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                grant_vld
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int               k;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      k         = 0;
      for (int i = 0; i < NUM_REQS; i++) begin
         k = int'(ptr_q) + i;
         if (k >= NUM_REQS) k = k - NUM_REQS;
         if (!grant_vld && req[k]) begin
            grant_vld = 1'b1;
            grant[k]  = 1'b1;
            grant_idx = IDX_W'(k);
         end
      end

      ptr_d = ptr_q;
      if (advance && grant_vld)
         ptr_d = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/vx_tex_dcr_seq.sv
// Texture descriptor loader: serialises one latched descriptor into DCR writes.
// Latency: first write the cycle after accept, one write per cycle, done on the last MIPOFF write.
// Backpressure: accepts only while idle; the DCR bus never stalls.
module vx_tex_dcr_seq
   import vx_tex_dcr_seq_pkg::*;
#(
   parameter  string INSTANCE_ID = "",
   parameter  int    NUM_REQS    = 2,
   parameter  int    NUM_STAGES  = 1,
   localparam int    STAGE_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
   localparam int    REQ_IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQS-1:0]               req_valid,
   input  logic [NUM_REQS-1:0][STAGE_W-1:0]  req_stage,
   input  tex_dcrs_t [NUM_REQS-1:0]          req_dcrs,
   output logic [NUM_REQS-1:0]               req_ready,
   output logic                              dcr_bus_write_valid,
   output logic [DCR_ADDR_W-1:0]             dcr_bus_write_addr,
   output logic [DCR_DATA_W-1:0]             dcr_bus_write_data,
   output logic                              done_valid,
   output logic [REQ_IDX_W-1:0]              done_id,
   output logic                              busy
);

   localparam int MIP_W = (TEX_MIP_CNT > 1) ? $clog2(TEX_MIP_CNT) : 1;

   tex_dcr_state_e     state_q, state_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [STAGE_W-1:0] last_stage_q, last_stage_d;
   logic               last_stage_vld_q, last_stage_vld_d;
   tex_dcrs_t          dcrs_q, dcrs_d;
   logic [REQ_IDX_W-1:0] id_q, id_d;
   logic [MIP_W-1:0]   mip_q, mip_d;

   logic [NUM_REQS-1:0]  grant;
   logic [REQ_IDX_W-1:0] grant_idx;
   logic                 grant_vld;
   logic                 idle, accept;

   assign idle   = (state_q == TEX_DCR_IDLE);
   assign accept = idle && grant_vld;

   vx_tex_dcr_seq_rr_arb #(.NUM_REQS(NUM_REQS)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign req_ready = idle ? grant : '0;
   assign done_id   = id_q;
   assign busy      = !idle;

   always_comb begin
      state_d             = state_q;
      stage_d             = stage_q;
      last_stage_d        = last_stage_q;
      last_stage_vld_d    = last_stage_vld_q;
      dcrs_d              = dcrs_q;
      id_d                = id_q;
      mip_d               = mip_q;
      dcr_bus_write_valid = 1'b0;
      dcr_bus_write_addr  = '0;
      dcr_bus_write_data  = '0;
      done_valid          = 1'b0;

      case (state_q)
         TEX_DCR_IDLE: begin
            if (accept) begin
               stage_d = req_stage[grant_idx];
               dcrs_d  = req_dcrs[grant_idx];
               id_d    = grant_idx;
               // Reprogramming the stage already selected on the bus is redundant.
               state_d = (last_stage_vld_q && req_stage[grant_idx] == last_stage_q)
                         ? TEX_DCR_ADDR : TEX_DCR_STAGE;
            end
         end
         TEX_DCR_STAGE: begin
            dcr_bus_write_valid = 1'b1;
            dcr_bus_write_addr  = DCR_TEX_STAGE;
            dcr_bus_write_data  = DCR_DATA_W'(stage_q);
            last_stage_d        = stage_q;
            last_stage_vld_d    = 1'b1;
            state_d             = TEX_DCR_ADDR;
         end
         TEX_DCR_ADDR: begin
            dcr_bus_write_valid = 1'b1;
            dcr_bus_write_addr  = DCR_TEX_ADDR;
            dcr_bus_write_data  = DCR_DATA_W'(dcrs_q.baseaddr);
            state_d             = TEX_DCR_FORMAT;
         end
         TEX_DCR_FORMAT: begin
            dcr_bus_write_valid = 1'b1;
            dcr_bus_write_addr  = DCR_TEX_FORMAT;
            dcr_bus_write_data  = DCR_DATA_W'(dcrs_q.format);
            state_d             = TEX_DCR_FILTER;
         end
         TEX_DCR_FILTER: begin
            dcr_bus_write_valid = 1'b1;
            dcr_bus_write_addr  = DCR_TEX_FILTER;
            dcr_bus_write_data  = DCR_DATA_W'(dcrs_q.filter);
            state_d             = TEX_DCR_WRAP;
         end
         TEX_DCR_WRAP: begin
            dcr_bus_write_valid = 1'b1;
            dcr_bus_write_addr  = DCR_TEX_WRAP;
            dcr_bus_write_data[TEX_WRAP_W-1:0]   = dcrs_q.wraps[0];
            dcr_bus_write_data[16 +: TEX_WRAP_W] = dcrs_q.wraps[1];
            state_d             = TEX_DCR_LOGDIM;
         end
         TEX_DCR_LOGDIM: begin
            dcr_bus_write_valid = 1'b1;
            dcr_bus_write_addr  = DCR_TEX_LOGDIM;
            dcr_bus_write_data[TEX_LOGDIM_W-1:0]   = dcrs_q.logdims[0];
            dcr_bus_write_data[16 +: TEX_LOGDIM_W] = dcrs_q.logdims[1];
            state_d             = TEX_DCR_MIPOFF;
         end
         TEX_DCR_MIPOFF: begin
            dcr_bus_write_valid = 1'b1;
            dcr_bus_write_addr  = dcr_tex_mipoff(DCR_ADDR_W'(mip_q));
            dcr_bus_write_data  = DCR_DATA_W'(dcrs_q.mipoff[mip_q]);
            if (mip_q == MIP_W'(TEX_LOD_MAX)) begin
               done_valid = 1'b1;
               mip_d      = '0;
               state_d    = TEX_DCR_IDLE;
            end else begin
               mip_d = mip_q + 1'b1;
            end
         end
         default: state_d = TEX_DCR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= TEX_DCR_IDLE;
         stage_q          <= '0;
         last_stage_q     <= '0;
         last_stage_vld_q <= 1'b0;
         dcrs_q           <= '0;
         id_q             <= '0;
         mip_q            <= '0;
      end else begin
         state_q          <= state_d;
         stage_q          <= stage_d;
         last_stage_q     <= last_stage_d;
         last_stage_vld_q <= last_stage_vld_d;
         dcrs_q           <= dcrs_d;
         id_q             <= id_d;
         mip_q            <= mip_d;
      end
   end

`ifdef DBG_TRACE_TEX
   always_ff @(posedge clk) begin
      if (dcr_bus_write_valid)
         $display("%s: tex-dcr-write addr=0x%0h data=0x%0h",
                  INSTANCE_ID, dcr_bus_write_addr, dcr_bus_write_data);
   end
`endif

endmodule

// File: tb/tb_vx_tex_dcr_seq.sv
// Directed bench for vx_tex_dcr_seq: hand-written vector table plus multi-cycle sequences.
module tb_vx_tex_dcr_seq;
   import vx_tex_dcr_seq_pkg::*;

   localparam int NR = 2;
   localparam int NS = 4;
   localparam int SW = 2;

   localparam logic [11:0] A_STAGE  = 12'h010;
   localparam logic [11:0] A_ADDR   = 12'h011;
   localparam logic [11:0] A_FORMAT = 12'h012;
   localparam logic [11:0] A_FILTER = 12'h013;
   localparam logic [11:0] A_WRAP   = 12'h014;
   localparam logic [11:0] A_LOGDIM = 12'h015;
   localparam logic [11:0] A_MIP0   = 12'h016;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NR-1:0]            req_valid;
   logic [NR-1:0][SW-1:0]    req_stage;
   tex_dcrs_t [NR-1:0]       req_dcrs;
   logic [NR-1:0]            req_ready;
   logic                     wv;
   logic [11:0]              waddr;
   logic [31:0]              wdata;
   logic                     done_valid;
   logic                     done_id;
   logic                     busy;

   always #5 clk = ~clk;

   vx_tex_dcr_seq #(.INSTANCE_ID("tb"), .NUM_REQS(NR), .NUM_STAGES(NS)) dut (
      .clk                 (clk),
      .reset               (reset),
      .req_valid           (req_valid),
      .req_stage           (req_stage),
      .req_dcrs            (req_dcrs),
      .req_ready           (req_ready),
      .dcr_bus_write_valid (wv),
      .dcr_bus_write_addr  (waddr),
      .dcr_bus_write_data  (wdata),
      .done_valid          (done_valid),
      .done_id             (done_id),
      .busy                (busy)
   );

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      logic        done;
   } vec_t;

   vec_t        tbl[10];
   int          tests = 0;
   int          fails = 0;
   logic [11:0] exp_addr[16];
   logic [31:0] exp_data[16];
   int          exp_n;
   tex_dcrs_t   d1, d2, dx;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic tex_dcrs_t mk(input logic [31:0] base, input logic [2:0] fmt, input logic flt,
                                    input logic [1:0] w0, input logic [1:0] w1,
                                    input logic [3:0] l0, input logic [3:0] l1, input logic [19:0] m0);
      tex_dcrs_t d;
      d            = '0;
      d.baseaddr   = base;
      d.format     = fmt;
      d.filter     = flt;
      d.wraps[0]   = w0;
      d.wraps[1]   = w1;
      d.logdims[0] = l0;
      d.logdims[1] = l1;
      for (int j = 0; j <= TEX_LOD_MAX; j++) d.mipoff[j] = m0 + 20'(j * 256);
      return d;
   endfunction

   task automatic push(input logic [11:0] a, input logic [31:0] v);
      exp_addr[exp_n] = a;
      exp_data[exp_n] = v;
      exp_n++;
   endtask

   task automatic build(input logic [SW-1:0] st, input tex_dcrs_t d, input bit skip);
      exp_n = 0;
      if (!skip) push(A_STAGE, 32'(st));
      push(A_ADDR, d.baseaddr);
      push(A_FORMAT, 32'(d.format));
      push(A_FILTER, 32'(d.filter));
      push(A_WRAP, {14'b0, d.wraps[1], 14'b0, d.wraps[0]});
      push(A_LOGDIM, {12'b0, d.logdims[1], 12'b0, d.logdims[0]});
      for (int j = 0; j <= TEX_LOD_MAX; j++) push(A_MIP0 + 12'(j), 32'(d.mipoff[j]));
   endtask

   // Called at the first write cycle; leaves the bench on the last write cycle.
   task automatic stream(input string tag, input int id);
      for (int i = 0; i < exp_n; i++) begin
         chk($sformatf("%s.wv%0d", tag, i), 32'(wv), 32'd1);
         chk($sformatf("%s.addr%0d", tag, i), 32'(waddr), 32'(exp_addr[i]));
         chk($sformatf("%s.data%0d", tag, i), wdata, exp_data[i]);
         chk($sformatf("%s.done%0d", tag, i), 32'(done_valid), (i == exp_n - 1) ? 32'd1 : 32'd0);
         chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
         if (i == exp_n - 1) chk($sformatf("%s.done_id", tag), 32'(done_id), 32'(id));
         if (i < exp_n - 1) begin @(negedge clk); #1; end
      end
   endtask

   // Drives a request while idle, scrambles req_* after accept, checks the full sequence.
   task automatic run(input string tag, input logic [NR-1:0] vld, input logic [NR-1:0] exp_rdy,
                      input int id, input logic [SW-1:0] st, input tex_dcrs_t d, input bit skip);
      req_valid = vld;
      #1;
      chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
      chk({tag, ".idle_wv"}, 32'(wv), 32'd0);
      @(negedge clk);
      req_valid = '0;
      req_dcrs  = {dx, dx};
      req_stage = {2'd3, 2'd3};
      #1;
      build(st, d, skip);
      stream(tag, id);
      @(negedge clk); #1;
      chk({tag, ".after_wv"}, 32'(wv), 32'd0);
      chk({tag, ".after_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      d1 = mk(32'h0000_1000, 3'd2, 1'b1, 2'd1, 2'd2, 4'd5, 4'd6, 20'h00100);
      d2 = mk(32'h0000_2000, 3'd5, 1'b0, 2'd3, 2'd0, 4'd7, 4'd9, 20'h00AB0);
      dx = mk(32'hDEAD_BEEF, 3'd7, 1'b1, 2'd3, 2'd3, 4'd15, 4'd15, 20'hF0F0F);

      tbl[0] = '{12'h010, 32'h0000_0001, 1'b0};
      tbl[1] = '{12'h011, 32'h0000_1000, 1'b0};
      tbl[2] = '{12'h012, 32'h0000_0002, 1'b0};
      tbl[3] = '{12'h013, 32'h0000_0001, 1'b0};
      tbl[4] = '{12'h014, 32'h0002_0001, 1'b0};
      tbl[5] = '{12'h015, 32'h0006_0005, 1'b0};
      tbl[6] = '{12'h016, 32'h0000_0100, 1'b0};
      tbl[7] = '{12'h017, 32'h0000_0200, 1'b0};
      tbl[8] = '{12'h018, 32'h0000_0300, 1'b0};
      tbl[9] = '{12'h019, 32'h0000_0400, 1'b1};

      reset     = 1'b1;
      req_valid = '0;
      req_stage = '0;
      req_dcrs  = '0;
      @(negedge clk); #1;
      chk("rst.wv", 32'(wv), 32'd0);
      chk("rst.done", 32'(done_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Single request, stage 1, against the hand-computed table.
      req_stage[0] = 2'd1;
      req_dcrs[0]  = d1;
      req_valid    = 2'b01;
      #1;
      chk("A.ready", 32'(req_ready), 32'h1);
      chk("A.idle_wv", 32'(wv), 32'd0);
      @(negedge clk);
      req_valid = '0;
      req_dcrs  = {dx, dx};
      req_stage = {2'd3, 2'd3};
      #1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("A.wv%0d", i), 32'(wv), 32'd1);
         chk($sformatf("A.addr%0d", i), 32'(waddr), 32'(tbl[i].addr));
         chk($sformatf("A.data%0d", i), wdata, tbl[i].data);
         chk($sformatf("A.done%0d", i), 32'(done_valid), 32'(tbl[i].done));
         if (tbl[i].done) chk("A.done_id", 32'(done_id), 32'd0);
         if (i < 9) begin @(negedge clk); #1; end
      end
      @(negedge clk); #1;
      chk("A.after_wv", 32'(wv), 32'd0);
      chk("A.after_busy", 32'(busy), 32'd0);

      // Same stage again: STAGE skipped, ADDR first.
      req_stage[0] = 2'd1;
      req_dcrs[0]  = d2;
      run("B", 2'b01, 2'b01, 0, 2'd1, d2, 1'b1);
      req_stage[1] = 2'd2;
      req_dcrs[1]  = d1;
      run("B2", 2'b10, 2'b10, 1, 2'd2, d1, 1'b0);
      req_stage[1] = 2'd1;
      req_dcrs[1]  = d2;
      run("B3", 2'b10, 2'b10, 1, 2'd1, d2, 1'b0);

      // Reset during FILTER abandons the sequence and forgets the last stage.
      req_stage[0] = 2'd1;
      req_dcrs[0]  = d1;
      req_valid    = 2'b01;
      #1;
      chk("D.ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("D.skip_addr", 32'(waddr), 32'(A_ADDR));
      @(negedge clk);
      @(negedge clk); #1;
      chk("D.filter_addr", 32'(waddr), 32'(A_FILTER));
      reset = 1'b1;
      #1;
      chk("D.rst_wv", 32'(wv), 32'd0);
      chk("D.rst_done", 32'(done_valid), 32'd0);
      chk("D.rst_busy", 32'(busy), 32'd0);
      @(negedge clk); #1;
      chk("D.rst_wv2", 32'(wv), 32'd0);
      chk("D.rst_done2", 32'(done_valid), 32'd0);
      reset     = 1'b0;
      req_stage = {2'd1, 2'd1};
      req_dcrs  = {d2, d1};
      run("D2", 2'b11, 2'b01, 0, 2'd1, d1, 1'b0);

      // Both requesters held valid: alternating grants, accept right after done.
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      req_stage = {2'd3, 2'd2};
      req_dcrs  = {d2, d1};
      req_valid = 2'b11;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk($sformatf("C.ready%0d", g), 32'(req_ready), (g % 2 == 1) ? 32'h2 : 32'h1);
         chk($sformatf("C.idle_wv%0d", g), 32'(wv), 32'd0);
         build((g % 2 == 1) ? 2'd3 : 2'd2, (g % 2 == 1) ? d2 : d1, 1'b0);
         @(negedge clk); #1;
         stream($sformatf("C%0d", g), g % 2);
         @(negedge clk);
      end
      req_valid = '0;
      #1;
      chk("C.end_wv", 32'(wv), 32'd0);
      @(negedge clk); #1;
      chk("C.end_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
